irq_controller: RTL and testbench

- Parametrised multi-source external interrupt controller.
- Replaces the single ExtIRQ/ExtIAck pair of the single-cycle LEGv8 core with NUM_IRQ edge-detected, maskable, fixed-priority request lines.
- Sits between peripherals and the core's controller/datapath.
- Presents one request plus the winning source ID to the core, and returns a per-line one-cycle acknowledge when the core takes the exception.

---
 rtl/irq_pkg.sv | 9 +
 rtl/irq_prio_enc.sv | 20 ++
 rtl/irq_controller.sv | 143 ++++++++++++++
 tb/tb_irq_controller.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and constants for the external interrupt controller.
package irq_pkg;

  typedef enum logic [1:0] {IDLE, PENDING, SERVICE} irq_state_t;

  // EStatus cause code the core controller reports for an external interrupt.
  localparam logic [3:0] EXT_IRQ_ESTATUS = 4'b0001;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: returns the winning request index and a valid flag.
module irq_prio_enc #(
  parameter int unsigned N   = 8,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  output logic [IDW-1:0] idx,
  output logic           valid
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    idx   = '0;
    valid = |req;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) idx = IDW'(i);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Multi-source edge-detected, maskable, fixed-priority interrupt controller for the LEGv8 core.
// Optional IRQ_SYNC_EN inserts a two-flop synchroniser per line ahead of edge detection.
module irq_controller
  import irq_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 8,
  parameter int unsigned ID_W    = $clog2(NUM_IRQ)
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               ExcAck,
  input  logic               ERet,
  output logic               ExtIRQ,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_IRQ-1:0] ExtIAck,
  output logic [NUM_IRQ-1:0] irq_mask,
  output logic [NUM_IRQ-1:0] pending,
  output logic               in_service
);

  logic [NUM_IRQ-1:0] edgeIn;
  logic [NUM_IRQ-1:0] irqPrev;
  logic [NUM_IRQ-1:0] riseVec;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] ackVec;
  logic [NUM_IRQ-1:0] clearVec;
  logic [ID_W-1:0]    winId;
  logic               winValid;

  irq_state_t         state;
  irq_state_t         stateNext;
  logic               extIrqNext;
  logic [ID_W-1:0]    irqIdNext;
  logic [NUM_IRQ-1:0] ackNext;
  logic               inServiceNext;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] syncMeta;
  logic [NUM_IRQ-1:0] syncOut;

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      syncMeta <= '0;
      syncOut  <= '0;
    end else begin
      syncMeta <= irq_in;
      syncOut  <= syncMeta;
    end
  end

  assign edgeIn = syncOut;
`else
  assign edgeIn = irq_in;
`endif

  assign riseVec  = edgeIn & ~irqPrev;
  assign eligible = pending & irq_mask;
  assign ackVec   = NUM_IRQ'(1) << irq_id;

  irq_prio_enc #(
    .N   (NUM_IRQ),
    .IDW (ID_W)
  ) prioEnc (
    .req   (eligible),
    .idx   (winId),
    .valid (winValid)
  );

  // Next-state and registered-output values; the latched id is never re-arbitrated in PENDING.
  always_comb begin
    stateNext     = state;
    extIrqNext    = ExtIRQ;
    irqIdNext     = irq_id;
    ackNext       = '0;
    inServiceNext = in_service;
    clearVec      = '0;
    unique case (state)
      IDLE: begin
        if (winValid) begin
          stateNext  = PENDING;
          extIrqNext = 1'b1;
          irqIdNext  = winId;
        end
      end
      PENDING: begin
        if (ExcAck) begin
          stateNext     = SERVICE;
          extIrqNext    = 1'b0;
          inServiceNext = 1'b1;
          ackNext       = ackVec;
          clearVec      = ackVec;
        end else if (!eligible[irq_id]) begin
          stateNext  = IDLE;
          extIrqNext = 1'b0;
        end
      end
      SERVICE: begin
        if (ERet) begin
          stateNext     = IDLE;
          inServiceNext = 1'b0;
        end
      end
      default: begin
        stateNext     = IDLE;
        extIrqNext    = 1'b0;
        inServiceNext = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state      <= IDLE;
      ExtIRQ     <= 1'b0;
      irq_id     <= '0;
      ExtIAck    <= '0;
      in_service <= 1'b0;
    end else begin
      state      <= stateNext;
      ExtIRQ     <= extIrqNext;
      irq_id     <= irqIdNext;
      ExtIAck    <= ackNext;
      in_service <= inServiceNext;
    end
  end

  // A rise arriving on the ack edge re-arms the line, so set takes priority over clear.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      irqPrev  <= '0;
      pending  <= '0;
      irq_mask <= '0;
    end else begin
      irqPrev <= edgeIn;
      pending <= (pending & ~clearVec) | riseVec;
      if (mask_we) irq_mask <= mask_wdata;
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus randomized traffic against a reference model.
module tb_irq_controller;

  localparam int unsigned NI = 8;
`ifdef IRQ_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic          CLOCK_50 = 1'b0;
  logic          reset;
  logic [NI-1:0] irqIn;
  logic          maskWe;
  logic [NI-1:0] maskWdata;
  logic          excAck;
  logic          eRet;
  logic          extIrq;
  logic [2:0]    irqId;
  logic [NI-1:0] extIAck;
  logic [NI-1:0] irqMask;
  logic [NI-1:0] pendingQ;
  logic          inService;

  int nChecks = 0;
  int nPass   = 0;

  // Reference model state: "asking" means a request is presented to the core.
  logic [NI-1:0] mPend, mMask, mPrev, mS1, mS2, mAck;
  int            mPhase;  // 0 quiet, 1 asking, 2 servicing
  int            mId;
  logic          mReq, mSvc;

  irq_controller #(.NUM_IRQ(NI)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .irq_in     (irqIn),
    .mask_we    (maskWe),
    .mask_wdata (maskWdata),
    .ExcAck     (excAck),
    .ERet       (eRet),
    .ExtIRQ     (extIrq),
    .irq_id     (irqId),
    .ExtIAck    (extIAck),
    .irq_mask   (irqMask),
    .pending    (pendingQ),
    .in_service (inService)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    else nPass++;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic modelEdge();
    logic [NI-1:0] seen, rises, elig, lowBit, clr;
    if (!reset) begin
      mPend = '0; mMask = '0; mPrev = '0; mS1 = '0; mS2 = '0; mAck = '0;
      mPhase = 0; mId = 0; mReq = 1'b0; mSvc = 1'b0;
      return;
    end
`ifdef IRQ_SYNC_EN
    seen = mS2;
`else
    seen = irqIn;
`endif
    rises = seen & ~mPrev;
    elig  = mPend & mMask;
    clr   = '0;
    mAck  = '0;
    if (mPhase == 0) begin
      if (elig != 0) begin
        lowBit = elig & (NI'(~elig) + NI'(1));
        mId    = $clog2(lowBit);
        mPhase = 1;
        mReq   = 1'b1;
      end
    end else if (mPhase == 1) begin
      if (excAck) begin
        mAck   = NI'(1) << mId;
        clr    = mAck;
        mPhase = 2;
        mReq   = 1'b0;
        mSvc   = 1'b1;
      end else if (elig[mId] == 1'b0) begin
        mPhase = 0;
        mReq   = 1'b0;
      end
    end else if (eRet) begin
      mPhase = 0;
      mSvc   = 1'b0;
    end
    mPend = (mPend & ~clr) | rises;
    if (maskWe) mMask = maskWdata;
    mPrev = seen;
    mS2   = mS1;
    mS1   = irqIn;
  endtask

  task automatic step(input logic [NI-1:0] irq, input logic we, input logic [NI-1:0] wd,
                      input logic ack, input logic er, input logic rst);
    irqIn = irq; maskWe = we; maskWdata = wd; excAck = ack; eRet = er; reset = rst;
    @(posedge CLOCK_50);
    modelEdge();
    #1;
    checkVal("ExtIRQ", 32'(extIrq), 32'(mReq));
    checkVal("ExtIAck", 32'(extIAck), 32'(mAck));
    checkVal("irq_mask", 32'(irqMask), 32'(mMask));
    checkVal("pending", 32'(pendingQ), 32'(mPend));
    checkVal("in_service", 32'(inService), 32'(mSvc));
    if (mReq || mSvc) checkVal("irq_id", 32'(irqId), 32'(mId));
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    irqIn = '0; maskWe = 1'b0; maskWdata = '0; excAck = 1'b0; eRet = 1'b0; reset = 1'b0;
    mPend = '0; mMask = '0; mPrev = '0; mS1 = '0; mS2 = '0; mAck = '0;
    mPhase = 0; mId = 0; mReq = 1'b0; mSvc = 1'b0;

    repeat (2) step('0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkVal("rst_ExtIRQ", 32'(extIrq), 32'd0);
    checkVal("rst_irq_id", 32'(irqId), 32'd0);
    checkVal("rst_pending", 32'(pendingQ), 32'd0);
    checkVal("rst_mask", 32'(irqMask), 32'd0);

    // Single pulse on line 5 through ack and return.
    step('0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
    step(8'h20, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(LAT);
    checkVal("t1_pending", 32'(pendingQ), 32'h20);
    checkVal("t1_noreq_yet", 32'(extIrq), 32'd0);
    idle(1);
    checkVal("t1_ExtIRQ", 32'(extIrq), 32'd1);
    checkVal("t1_id", 32'(irqId), 32'd5);
    step('0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    checkVal("t1_ack", 32'(extIAck), 32'h20);
    checkVal("t1_pend_clr", 32'(pendingQ), 32'h00);
    checkVal("t1_insvc", 32'(inService), 32'd1);
    step('0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    checkVal("t1_ack_once", 32'(extIAck), 32'h00);
    checkVal("t1_eret", 32'(inService), 32'd0);

    // Lines 6 and 2 together: 2 wins, 6 follows after one idle cycle.
    step(8'h44, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(LAT + 1);
    checkVal("t2_id_first", 32'(irqId), 32'd2);
    step('0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    checkVal("t2_ack2", 32'(extIAck), 32'h04);
    step('0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    checkVal("t2_idle_gap", 32'(extIrq), 32'd0);
    idle(1);
    checkVal("t2_req_second", 32'(extIrq), 32'd1);
    checkVal("t2_id_second", 32'(irqId), 32'd6);
    step('0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    step('0, 1'b0, '0, 1'b0, 1'b1, 1'b1);

    // Masked arrival is held pending until enabled.
    step('0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    step(8'h08, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(LAT + 1);
    checkVal("t3_pending", 32'(pendingQ), 32'h08);
    checkVal("t3_masked", 32'(extIrq), 32'd0);
    step('0, 1'b1, 8'h08, 1'b0, 1'b0, 1'b1);
    idle(1);
    checkVal("t3_req", 32'(extIrq), 32'd1);
    checkVal("t3_id", 32'(irqId), 32'd3);
    step('0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    step('0, 1'b0, '0, 1'b0, 1'b1, 1'b1);

    // Masking the latched line while asking withdraws the request.
    step('0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
    step(8'h10, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(LAT + 1);
    checkVal("t4_id", 32'(irqId), 32'd4);
    step('0, 1'b1, 8'hEF, 1'b0, 1'b0, 1'b1);
    idle(1);
    checkVal("t4_withdrawn", 32'(extIrq), 32'd0);
    checkVal("t4_still_pend", 32'(pendingQ[4]), 32'd1);
    checkVal("t4_no_ack", 32'(extIAck), 32'h00);

    // Rise on line 1 coinciding with its own ack keeps it pending; reset in SERVICE clears all.
    for (int k = 0; k <= LAT + 2; k++)
      step((k == 0 || k >= 2) ? 8'h02 : 8'h00, 1'b0, '0, (k == LAT + 2), 1'b0, 1'b1);
    checkVal("t5_ack1", 32'(extIAck), 32'h02);
    checkVal("t5_rearmed", 32'(pendingQ[1]), 32'd1);
    step(8'h02, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(8'h02, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkVal("t5_rst_svc", 32'(inService), 32'd0);
    checkVal("t5_rst_pend", 32'(pendingQ), 32'd0);
    checkVal("t5_rst_ack", 32'(extIAck), 32'd0);
    checkVal("t5_rst_id", 32'(irqId), 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      logic [NI-1:0] r;
      r = NI'($urandom) & NI'($urandom) & NI'($urandom);
      step(r, ($urandom_range(0, 7) == 0), NI'($urandom),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 149) != 0));
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
